multicycle_control: RTL and testbench

//  Multi-cycle successor to the single-cycle MIPS-lite decoder: a Moore FSM

---
 rtl/mc_ctrl_pkg.sv | 86 ++++++++
 rtl/mc_ctrl_decode.sv | 89 ++++++++
 rtl/multicycle_control.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-lite control unit:
// opcodes, FSM state encoding, datapath mux encodings and the control bundle.
package mc_ctrl_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_NORI  = 6'b001101;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_JSP   = 6'b010010;

  // FSM states, one per datapath step
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_RWB    = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_JSP_RD = 4'd11,
    S_JSP_PC = 4'd12
  } state_e;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NORI  = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_MDR    = 2'b11;

  // Every datapath control driven by the FSM, decoded from the state
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdest;
    logic       regwrite;
    logic       alusrca;
    logic       jal;
    logic       jsp;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

  // True for the seven opcodes this control unit sequences
  function automatic logic is_legal_op(input logic [5:0] opc);
    case (opc)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
      OP_NORI, OP_JAL, OP_JSP: is_legal_op = 1'b1;
      default:                 is_legal_op = 1'b0;
    endcase
  endfunction

  // True for states whose completion retires an instruction
  function automatic logic is_last_state(input state_e s);
    case (s)
      S_RWB, S_MEMWB, S_MEMWR,
      S_BRANCH, S_JUMP, S_JSP_PC: is_last_state = 1'b1;
      default:                    is_last_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: maps the current FSM state onto the datapath control
// bundle. Purely combinational; the only extra input is the R-type/nori flag
// captured in DECODE, which selects the write-back destination register.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e i_state,
  input  logic   i_rwb_rtype,
  output ctrl_t  o_ctrl
);

  // Decode state into datapath enables and mux selects
  always_comb begin
    // NOTE: every field defaults to 0 before the case so no path through the
    // block leaves an output unassigned, which would otherwise infer a latch.
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.memread  = 1'b1;
        o_ctrl.irwrite  = 1'b1;
        o_ctrl.pcwrite  = 1'b1;
        o_ctrl.alusrcb  = SRCB_FOUR;
        o_ctrl.aluop    = ALUOP_ADD;
        o_ctrl.pcsource = PCSRC_ALU;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut
        o_ctrl.alusrcb = SRCB_IMM_SH2;
      end
      S_EXEC_R: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_REGB;
        o_ctrl.aluop   = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
        o_ctrl.aluop   = ALUOP_NORI;
      end
      S_RWB: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.regdest  = i_rwb_rtype;
      end
      S_MEMADR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.memread = 1'b1;
        o_ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.memwrite = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alusrca     = 1'b1;
        o_ctrl.aluop       = ALUOP_SUB;
        o_ctrl.pcwritecond = 1'b1;
        o_ctrl.pcsource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        // Jump and link: PC <- target, $ra <- return address
        o_ctrl.pcwrite  = 1'b1;
        o_ctrl.pcsource = PCSRC_JUMP;
        o_ctrl.jal      = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      S_JSP_RD: begin
        // Read the word at $sp (address routed through the ALU)
        o_ctrl.memread = 1'b1;
        o_ctrl.iord    = 1'b1;
        o_ctrl.jsp     = 1'b1;
      end
      S_JSP_PC: begin
        // Load PC from the word just read into MDR
        o_ctrl.pcwrite  = 1'b1;
        o_ctrl.pcsource = PCSRC_MDR;
        o_ctrl.jsp      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-lite control unit: Moore FSM sequencing FETCH/DECODE/
// EXECUTE/MEM/WB, a retired-instruction counter, and an optional memory
// wait/timeout mechanism enabled by defining MULTICYCLE_CONTROL_MEM_WAIT_EN.
// All outputs are held at 0 while rst_n is low.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W  = 6,
  parameter int CNT_W = 32,
  parameter int TMO_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdest,
  output logic             regwrite,
  output logic             alusrca,
  output logic             jal,
  output logic             jsp,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             illegal_op,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);

  state_e           r_state;
  state_e           w_next;
  state_e           w_adv;
  logic             r_rwb_rtype;
  logic [CNT_W-1:0] r_retired;
  logic [5:0]       w_op;
  ctrl_t            w_ctrl;
  logic             w_stall;
  logic             w_timeout;
  logic             w_retire;
  logic             w_illegal;

  assign w_op = 6'(op);

`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  logic             w_mem_state;
  logic [TMO_W-1:0] r_tmo;

  // States that talk to memory and must wait for mem_ready
  assign w_mem_state = (r_state == S_FETCH)  || (r_state == S_MEMRD) ||
                       (r_state == S_MEMWR)  || (r_state == S_JSP_RD);
  // A ready response on the final waiting cycle beats the timeout
  assign w_timeout   = w_mem_state && !mem_ready && (r_tmo == TMO_MAX);
  assign w_stall     = w_mem_state && !mem_ready && !w_timeout;

  // Count consecutive waiting cycles; clear whenever the state is left
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (w_stall) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end else begin
      r_tmo <= '0;
    end
  end
`else
  logic w_unused;

  // Memory always completes in one cycle; mem_ready has no effect
  assign w_timeout = 1'b0;
  assign w_stall   = 1'b0;
  assign w_unused  = mem_ready | (TMO_W < 1);
`endif

  assign w_illegal = (r_state == S_DECODE) && !is_legal_op(w_op);
  assign w_retire  = is_last_state(r_state) && !w_stall && !w_timeout;

  // State register, plus the R-type flag captured in DECODE for write-back
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_rwb_rtype <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_rwb_rtype <= (w_op == OP_RTYPE);
      end
    end
  end

  // Next-state logic: nominal successor, then stall/timeout overrides
  always_comb begin
    w_adv = S_FETCH;
    case (r_state)
      S_FETCH:  w_adv = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_RTYPE:     w_adv = S_EXEC_R;
          OP_NORI:      w_adv = S_EXEC_I;
          OP_LW, OP_SW: w_adv = S_MEMADR;
          OP_BEQ:       w_adv = S_BRANCH;
          OP_JAL:       w_adv = S_JUMP;
          OP_JSP:       w_adv = S_JSP_RD;
          default:      w_adv = S_FETCH;
        endcase
      end
      S_EXEC_R: w_adv = S_RWB;
      S_EXEC_I: w_adv = S_RWB;
      S_RWB:    w_adv = S_FETCH;
      S_MEMADR: w_adv = (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_adv = S_MEMWB;
      S_MEMWB:  w_adv = S_FETCH;
      S_MEMWR:  w_adv = S_FETCH;
      S_BRANCH: w_adv = S_FETCH;
      S_JUMP:   w_adv = S_FETCH;
      S_JSP_RD: w_adv = S_JSP_PC;
      S_JSP_PC: w_adv = S_FETCH;
      default:  w_adv = S_FETCH;
    endcase

    w_next = w_adv;
    if (w_stall) begin
      w_next = r_state;
    end
    if (w_timeout) begin
      w_next = S_FETCH;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  mc_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_rwb_rtype (r_rwb_rtype),
    .o_ctrl      (w_ctrl)
  );

  // Output stage: drive decoded controls, forced to 0 while reset is held
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdest     = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    jal         = 1'b0;
    jsp         = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    illegal_op  = 1'b0;
    mem_err     = 1'b0;
    retired     = '0;
    if (rst_n) begin
      pcwrite     = w_ctrl.pcwrite;
      pcwritecond = w_ctrl.pcwritecond;
      iord        = w_ctrl.iord;
      memread     = w_ctrl.memread;
      memwrite    = w_ctrl.memwrite;
      irwrite     = w_ctrl.irwrite;
      memtoreg    = w_ctrl.memtoreg;
      regdest     = w_ctrl.regdest;
      regwrite    = w_ctrl.regwrite;
      alusrca     = w_ctrl.alusrca;
      jal         = w_ctrl.jal;
      jsp         = w_ctrl.jsp;
      alusrcb     = w_ctrl.alusrcb;
      aluop       = w_ctrl.aluop;
      pcsource    = w_ctrl.pcsource;
      illegal_op  = w_illegal;
      mem_err     = w_timeout;
      retired     = r_retired;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Each instruction pushes its expected
// per-cycle control vectors and retired count into a scoreboard queue; every
// cycle pops one entry and compares it with the DUT outputs at the falling edge.
module tb_multicycle_control;

  localparam int OP_W  = 6;
  localparam int CNT_W = 4;
  localparam int TMO_W = 4;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_NORI = 6'b001101;
  localparam logic [5:0] T_JAL  = 6'b000011;
  localparam logic [5:0] T_JSP  = 6'b010010;
  localparam logic [5:0] T_ILL  = 6'b111111;

  // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdest,
  //  regwrite,alusrca,jal,jsp,alusrcb[2],aluop[2],pcsource[2],illegal_op,mem_err}
  typedef logic [19:0] vec_t;
  localparam vec_t V_ZERO     = 20'b0_0_0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam vec_t V_FETCH    = 20'b1_0_0_1_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam vec_t V_DECODE   = 20'b0_0_0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam vec_t V_DEC_ILL  = 20'b0_0_0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
  localparam vec_t V_EXEC_R   = 20'b0_0_0_0_0_0_0_0_0_1_0_0_00_10_00_0_0;
  localparam vec_t V_EXEC_I   = 20'b0_0_0_0_0_0_0_0_0_1_0_0_10_11_00_0_0;
  localparam vec_t V_RWB_R    = 20'b0_0_0_0_0_0_0_1_1_0_0_0_00_00_00_0_0;
  localparam vec_t V_RWB_I    = 20'b0_0_0_0_0_0_0_0_1_0_0_0_00_00_00_0_0;
  localparam vec_t V_MEMADR   = 20'b0_0_0_0_0_0_0_0_0_1_0_0_10_00_00_0_0;
  localparam vec_t V_MEMRD    = 20'b0_0_1_1_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam vec_t V_MEMRD_TO = 20'b0_0_1_1_0_0_0_0_0_0_0_0_00_00_00_0_1;
  localparam vec_t V_MEMWB    = 20'b0_0_0_0_0_0_1_0_1_0_0_0_00_00_00_0_0;
  localparam vec_t V_MEMWR    = 20'b0_0_1_0_1_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam vec_t V_BRANCH   = 20'b0_1_0_0_0_0_0_0_0_1_0_0_00_01_01_0_0;
  localparam vec_t V_JUMP     = 20'b1_0_0_0_0_0_0_0_1_0_1_0_00_00_10_0_0;
  localparam vec_t V_JSP_RD   = 20'b0_0_1_1_0_0_0_0_0_0_0_1_00_00_00_0_0;
  localparam vec_t V_JSP_PC   = 20'b1_0_0_0_0_0_0_0_0_0_0_1_00_00_11_0_0;

  typedef struct {
    vec_t             v;
    logic [CNT_W-1:0] ret;
    string            tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [OP_W-1:0]  op;
  logic             mem_ready;
  logic             pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic             memtoreg, regdest, regwrite, alusrca, jal, jsp;
  logic [1:0]       alusrcb, aluop, pcsource;
  logic             illegal_op, mem_err;
  logic [CNT_W-1:0] retired;
  vec_t             obs;

  exp_t             q[$];
  logic [CNT_W-1:0] m_ret;
  int               total = 0;
  int               bad   = 0;

  always #5 clk = ~clk;

  assign obs = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                memtoreg, regdest, regwrite, alusrca, jal, jsp,
                alusrcb, aluop, pcsource, illegal_op, mem_err};

  multicycle_control #(
    .OP_W  (OP_W),
    .CNT_W (CNT_W),
    .TMO_W (TMO_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .mem_ready   (mem_ready),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .memtoreg    (memtoreg),
    .regdest     (regdest),
    .regwrite    (regwrite),
    .alusrca     (alusrca),
    .jal         (jal),
    .jsp         (jsp),
    .alusrcb     (alusrcb),
    .aluop       (aluop),
    .pcsource    (pcsource),
    .illegal_op  (illegal_op),
    .mem_err     (mem_err),
    .retired     (retired)
  );

  task automatic push(input vec_t v, input string tag);
    exp_t e;
    e.v   = v;
    e.ret = m_ret;
    e.tag = tag;
    q.push_back(e);
  endtask

  // Compare one cycle at the falling edge, then step to just after the next rise
  task automatic tick();
    exp_t e;
    @(negedge clk);
    total++;
    assert (q.size() != 0) else begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0d expected>0", q.size());
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      total++;
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s ctrl observed=%b expected=%b", e.tag, obs, e.v);
      end
      total++;
      assert (retired === e.ret) else begin
        bad++;
        $error("FAIL %s retired observed=%0d expected=%0d", e.tag, retired, e.ret);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Push the full expected state sequence of one instruction
  task automatic expect_instr(input logic [5:0] opc, input string tag);
    push(V_FETCH, {tag, ".fetch"});
    case (opc)
      T_R:    begin push(V_DECODE, {tag, ".dec"}); push(V_EXEC_R, {tag, ".exec"});
                    push(V_RWB_R, {tag, ".rwb"}); end
      T_NORI: begin push(V_DECODE, {tag, ".dec"}); push(V_EXEC_I, {tag, ".exec"});
                    push(V_RWB_I, {tag, ".rwb"}); end
      T_LW:   begin push(V_DECODE, {tag, ".dec"}); push(V_MEMADR, {tag, ".adr"});
                    push(V_MEMRD, {tag, ".memrd"}); push(V_MEMWB, {tag, ".memwb"}); end
      T_SW:   begin push(V_DECODE, {tag, ".dec"}); push(V_MEMADR, {tag, ".adr"});
                    push(V_MEMWR, {tag, ".memwr"}); end
      T_BEQ:  begin push(V_DECODE, {tag, ".dec"}); push(V_BRANCH, {tag, ".br"}); end
      T_JAL:  begin push(V_DECODE, {tag, ".dec"}); push(V_JUMP, {tag, ".jump"}); end
      T_JSP:  begin push(V_DECODE, {tag, ".dec"}); push(V_JSP_RD, {tag, ".jsprd"});
                    push(V_JSP_PC, {tag, ".jsppc"}); end
      default: push(V_DEC_ILL, {tag, ".dec_ill"});
    endcase
    if (opc != T_ILL) m_ret = m_ret + 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] opc, input string tag);
    op = opc;
    expect_instr(opc, tag);
    while (q.size() != 0) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] prog [6];
    rst_n     = 1'b0;
    op        = T_ILL;
    mem_ready = 1'b1;
    m_ret     = '0;
    prog      = '{T_R, T_NORI, T_SW, T_BEQ, T_JAL, T_JSP};

    // Reset held for two cycles: all outputs zero
    @(posedge clk);
    #1;
    push(V_ZERO, "reset0");
    tick();
    push(V_ZERO, "reset1");
    tick();
    rst_n = 1'b1;

    // lw: 5 cycles, retired 0 -> 1 seen on the next fetch
    run_instr(T_LW, "lw");

    // Mixed program, latencies 4,4,4,3,3,4
    for (int i = 0; i < 6; i++) begin
      run_instr(prog[i], $sformatf("prog%0d", i));
    end

    // Illegal opcode: pulse in DECODE, back to FETCH, no retire
    run_instr(T_ILL, "ill");

    // Reset during MEMRD of a lw aborts it
    op = T_LW;
    push(V_FETCH, "abort.fetch");
    push(V_DECODE, "abort.dec");
    push(V_MEMADR, "abort.adr");
    repeat (3) tick();
    rst_n = 1'b0;
    m_ret = '0;
    push(V_ZERO, "abort.rst");
    tick();
    rst_n = 1'b1;
    run_instr(T_BEQ, "after_abort");

`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
    // MEMRD waits three cycles, then completes
    op = T_LW;
    push(V_FETCH, "wait.fetch");
    push(V_DECODE, "wait.dec");
    push(V_MEMADR, "wait.adr");
    repeat (3) tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(V_MEMRD, $sformatf("wait.memrd%0d", i));
      tick();
    end
    mem_ready = 1'b1;
    push(V_MEMRD, "wait.memrd_go");
    push(V_MEMWB, "wait.memwb");
    m_ret = m_ret + 1'b1;
    repeat (2) tick();

    // MEMRD never ready: 15 waiting cycles then mem_err and FETCH
    push(V_FETCH, "tmo.fetch");
    push(V_DECODE, "tmo.dec");
    push(V_MEMADR, "tmo.adr");
    repeat (3) tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      push(V_MEMRD, $sformatf("tmo.wait%0d", i));
      tick();
    end
    push(V_MEMRD_TO, "tmo.err");
    tick();
    mem_ready = 1'b1;
    run_instr(T_BEQ, "after_tmo");
`endif

    // Counter wrap: reset, then 16 beq on a 4-bit counter returns to 0
    rst_n = 1'b0;
    m_ret = '0;
    push(V_ZERO, "wrap.rst");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      run_instr(T_BEQ, $sformatf("wrap%0d", i));
    end
    push(V_FETCH, "wrap.final");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
